// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF/ID fetch/decode buffer.
// Holds the FSM state encoding and the packed packet format handed to decode.
package fetch_pkg;

    localparam int          PKT_PC_W     = 32;
    localparam int          IMM_FLAG_BIT = 10;
    localparam logic [15:0] NOP_WORD     = 16'h0000;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0]         instr;
        logic [15:0]         imm;
        logic [PKT_PC_W-1:0] pc;
        logic                has_imm;
        logic                valid;
    } pkt_t;

endpackage

// File: rtl/fetch_decode_buffer.sv
// IF/ID buffer: merges opcode+immediate word pairs into one packet, 1-cycle latency.
// Stall freezes all state (o_pc_hold = i_stall); FETCH_BUF_PERF_EN adds o_bubble_cnt.
module fetch_decode_buffer #(
    parameter int          PC_W         = 32,
    parameter int          IMM_FLAG_BIT = fetch_pkg::IMM_FLAG_BIT,
    parameter logic [15:0] NOP_WORD     = fetch_pkg::NOP_WORD
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic [15:0]     o_instr,
    output logic [15:0]     o_imm,
    output logic [PC_W-1:0] o_pc,
    output logic            o_has_imm,
    output logic            o_valid,
`ifdef FETCH_BUF_PERF_EN
    output logic [31:0]     o_bubble_cnt,
`endif
    output logic            o_pc_hold
);

    import fetch_pkg::*;

    state_t          state_q, state_d;
    logic [15:0]     pend_instr_q, pend_instr_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    pkt_t            out_q, out_d;
    logic            hold;

    assign hold = i_stall && !i_flush;

    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        out_d        = out_q;

        // Default to a bubble; o_pc deliberately keeps its last value.
        if (!hold) begin
            out_d.instr   = NOP_WORD;
            out_d.imm     = 16'h0000;
            out_d.has_imm = 1'b0;
            out_d.valid   = 1'b0;
        end

        if (i_flush) begin
            state_d      = S_OP;
            pend_instr_d = 16'h0000;
            pend_pc_d    = '0;
        end else if (!i_stall && i_valid) begin
            unique case (state_q)
                S_OP: begin
                    if (i_instr[IMM_FLAG_BIT]) begin
                        pend_instr_d = i_instr;
                        pend_pc_d    = i_pc;
                        state_d      = S_IMM;
                    end else begin
                        out_d.instr = i_instr;
                        out_d.pc    = PKT_PC_W'(i_pc);
                        out_d.valid = 1'b1;
                    end
                end
                S_IMM: begin
                    out_d.instr   = pend_instr_q;
                    out_d.pc      = PKT_PC_W'(pend_pc_q);
                    out_d.imm     = i_instr;
                    out_d.has_imm = 1'b1;
                    out_d.valid   = 1'b1;
                    state_d       = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= S_OP;
            pend_instr_q  <= 16'h0000;
            pend_pc_q     <= '0;
            out_q.instr   <= NOP_WORD;
            out_q.imm     <= 16'h0000;
            out_q.pc      <= '0;
            out_q.has_imm <= 1'b0;
            out_q.valid   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
            out_q        <= out_d;
        end
    end

`ifdef FETCH_BUF_PERF_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            bubble_cnt_q <= 32'd0;
        end else if (!hold && !out_d.valid) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
`endif

    assign o_instr   = out_q.instr;
    assign o_imm     = out_q.imm;
    assign o_pc      = out_q.pc[PC_W-1:0];
    assign o_has_imm = out_q.has_imm;
    assign o_valid   = out_q.valid;
    assign o_pc_hold = i_stall;

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
IF/ID pipeline register directly downstream of the fetch stage. Takes one 16-bit instruction word per cycle from instruction memory and assembles two-word instructions (opcode word plus trailing 16-bit immediate word) into a single decode-ready packet. Carries the packet's PC, inserts bubbles, and honours stall from the hazard unit and flush from branch/interrupt resolution.

Parameters:
- PC_W, 32, PC width; matches the program counter.
- IMM_FLAG_BIT, 10, bit of the opcode word that marks "immediate word follows".
- NOP_WORD, 16'h0000, encoding driven on o_instr for bubbles.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_instr  in  16  word from instruction memory.
- i_pc  in  PC_W  address of i_instr.
- i_valid  in  1  i_instr/i_pc valid this cycle.
- i_stall  in  1  hazard unit: hold all state.
- i_flush  in  1  discard everything in flight.
- o_instr  out  16  opcode word to decode.
- o_imm  out  16  immediate word; 0 when o_has_imm = 0.
- o_pc  out  PC_W  PC of the opcode word.
- o_has_imm  out  1  packet is a two-word instruction.
- o_valid  out  1  packet valid.
- o_pc_hold  out  1  tells fetch to hold its PC (= i_stall, combinational).

Behaviour:
- Reset (i_reset = 0 at a clock edge): state = S_OP; o_instr = NOP_WORD; o_imm = 0; o_pc = 0; o_has_imm = 0; o_valid = 0; pending regs = 0.
- Priority at each edge: reset > flush > stall > normal.
- States: S_OP (expect opcode word) and S_IMM (opcode held, expect immediate).
- Pending regs pend_instr and pend_pc hold the opcode word while in S_IMM. Output regs are separate from them.
- S_OP with i_valid and i_instr[IMM_FLAG_BIT] = 0:
  - next cycle o_instr = i_instr, o_pc = i_pc, o_imm = 0, o_has_imm = 0, o_valid = 1.
  - stays in S_OP.
  - latency is 1 cycle.
- S_OP with i_valid and i_instr[IMM_FLAG_BIT] = 1:
  - pend_instr ← i_instr, pend_pc ← i_pc.
  - next cycle outputs a bubble (o_valid = 0, o_instr = NOP_WORD, o_has_imm = 0).
  - goes to S_IMM.
- S_IMM with i_valid:
  - o_instr = pend_instr, o_pc = pend_pc, o_imm = i_instr, o_has_imm = 1, o_valid = 1.
  - goes to S_OP.
  - the flag bit of the immediate word is ignored.
- i_valid = 0 in either state: output a bubble; state and pending regs hold.
- Stall (i_stall = 1, i_flush = 0): every register holds, including state, pending and outputs; o_pc_hold = 1. A stall arriving while in S_IMM keeps the pending opcode.
- Flush (i_flush = 1): state = S_OP; pending regs cleared; output a bubble. Flush wins over a simultaneous stall and over i_valid.
- Bubble outputs: o_pc holds its previous value; every other output is at its bubble value.
- Reset mid-operation: a half-assembled two-word instruction is dropped, with no partial packet emitted.
- Widths: no arithmetic; all paths pass through unchanged.

Optional Feature:
- Macro FETCH_BUF_PERF_EN.
- When defined:
  - adds output o_bubble_cnt, 32 bits.
  - the counter increments on every edge where o_valid is 0 next cycle, excluding reset and stall cycles.
  - it wraps at 2^32 − 1 → 0 and clears on reset.
- When undefined: no port, no counter, and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {S_OP, S_IMM};
  - constants NOP_WORD and IMM_FLAG_BIT;
  - a packed struct for the IF/ID packet {instr, imm, pc, has_imm, valid}.
- No sub-module is needed: a single FSM plus registers. The perf counter is an inline conditional block.

Test Plan:
1. Single-word stream, i_valid = 1: 16'h1234 @ pc 5, then 16'h2000 @ pc 6 → o_instr 16'h1234, o_pc 5, o_valid 1 one cycle later, then 16'h2000, o_pc 6. o_has_imm stays 0.
2. Two-word: 16'h0400 (bit10 = 1) @ pc 8, then 16'hBEEF @ pc 9 → one bubble cycle, then o_instr 16'h0400, o_imm 16'hBEEF, o_pc 8, o_has_imm 1, o_valid 1.
3. Stall in S_IMM: after 16'h0400 @ pc 8, assert i_stall for 3 cycles, then deliver 16'hBEEF → outputs frozen and o_pc_hold 1 during the stall; afterwards the packet is {0400, BEEF, pc 8}.
4. Flush in S_IMM with a simultaneous stall: after 16'h0400, assert i_flush = i_stall = 1 → next o_valid 0 and o_instr 0000. A following word 16'h1111 @ pc 20 is treated as an opcode word (o_instr 1111, o_has_imm 0).
5. Reset mid-operation: i_reset = 0 while in S_IMM → all outputs zero, state S_OP. A subsequent 16'hBEEF is treated as an opcode word (bit10 = 1, so the FSM goes to S_IMM and outputs a bubble).
6. i_valid gaps: opcode 16'h0400, i_valid = 0 for 2 cycles, then 16'h00AA → bubbles during the gap, then packet {0400, 00AA}. With FETCH_BUF_PERF_EN, o_bubble_cnt = 3.
